reset_seq: RTL and testbench

Reset sequencer that consumes the power-on reset and drives ordered, per-domain resets into the capture fabric.
- Holds every stage in reset until the PLL is locked and a minimum hold time has elapsed.
- Releases stages one at a time, waiting for each stage's ready/ack before moving on.
- Re-enters full reset on PLL lock loss or a host soft-reset request.

---
 rtl/reset_seq_pkg.sv | 18 +
 rtl/reset_sync_bit.sv | 18 +
 rtl/reset_seq.sv | 104 ++++++++++
 tb/tb_reset_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: state encoding and counter sizing shared by the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_WAIT_ACK,
    ST_GAP,
    ST_DONE
  } state_t;

  function automatic int cnt_width(input int hold, input int gap, input int tmo);
    int m;
    m = hold > gap ? hold : gap;
    m = m > tmo ? m : tmo;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_sync_bit.sv
// reset_sync_bit: 2-flop synchroniser for a single asynchronous level, cleared to 0 by rst_i.
module reset_sync_bit (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] r_ff;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_ff <= 2'b00;
    else       r_ff <= {r_ff[0], d_i};
  end

  assign q_o = r_ff[1];

endmodule

// File: rtl/reset_seq.sv
// reset_seq: holds all domains in reset until lock plus hold time, then releases them
// one at a time in index order, each gated on the previous stage's ack (or its timeout).
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  lock_i,
  input  logic                  soft_rst_i,
  input  logic [NUM_STAGES-1:0] stage_ack_i,
  output logic [NUM_STAGES-1:0] rst_o,
  output logic                  busy_o,
  output logic                  ready_o,
  output logic                  timeout_o
);

  localparam int CW = cnt_width(HOLD_CYCLES, STAGE_GAP, ACK_TIMEOUT);
  localparam int IW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(ACK_TIMEOUT > 0 ? ACK_TIMEOUT - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_STAGES - 1);

  state_t                r_state, w_state;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic [IW-1:0]         r_idx, w_idx;
  logic [NUM_STAGES-1:0] r_rst, w_rst;
  logic                  r_to, w_to;
  logic                  w_lock_s, w_abort, w_ack, w_tmo;

  reset_sync_bit u_lock_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (lock_i),
    .q_o   (w_lock_s)
  );

  assign w_abort = soft_rst_i | ~w_lock_s;
  assign w_ack   = stage_ack_i[r_idx];
  assign w_tmo   = (ACK_TIMEOUT > 0) && (r_cnt == TO_LAST);

  // Released stages always form a low-order prefix, so releasing the next one is a left shift.
  always_comb begin
    w_state = r_state;
    w_cnt   = (r_state == ST_DONE || (r_state == ST_WAIT_ACK && ACK_TIMEOUT == 0)) ? r_cnt : r_cnt + 1'b1;
    w_idx   = r_idx;
    w_rst   = r_rst;
    w_to    = r_to;
    if (w_abort) begin
      w_state = ST_ASSERT;
      w_cnt   = '0;
      w_idx   = '0;
      w_rst   = '1;
      w_to    = 1'b0;
    end else begin
      case (r_state)
        ST_ASSERT: if (r_cnt == HOLD_LAST) begin
          w_state = ST_WAIT_ACK;
          w_cnt   = '0;
          w_rst   = r_rst << 1;
        end
        ST_WAIT_ACK: if (w_ack || w_tmo) begin
          w_state = (r_idx == LAST_IDX) ? ST_DONE : ST_GAP;
          w_cnt   = '0;
          w_to    = r_to | ~w_ack;
        end
        ST_GAP: if (r_cnt == GAP_LAST) begin
          w_state = ST_WAIT_ACK;
          w_cnt   = '0;
          w_idx   = r_idx + 1'b1;
          w_rst   = r_rst << 1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_ASSERT;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rst   <= '1;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_rst   <= w_rst;
      r_to    <= w_to;
    end
  end

  assign rst_o     = r_rst;
  assign busy_o    = r_state != ST_DONE;
  assign ready_o   = r_state == ST_DONE;
  assign timeout_o = r_to;

endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: directed checks of release ordering, timeout, abort and reset behaviour.
module tb_reset_seq;

  typedef struct {
    int         e;
    logic [2:0] r;
    logic       b;
    logic       rd;
    logic       t;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       lock_i = 1'b1;
  logic       soft_rst_i = 1'b0;
  logic [2:0] ack = 3'b111;
  logic [2:0] rst_o, rst_o_nt;
  logic       busy_o, ready_o, timeout_o, busy_nt, ready_nt, timeout_nt;
  int         edge_n = 0;
  int         tests = 0;
  int         fails = 0;
  int         l, a, r;
  vec_t       tbl [8];

  always #5 clk = ~clk;

  reset_seq dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .lock_i      (lock_i),
    .soft_rst_i  (soft_rst_i),
    .stage_ack_i (ack),
    .rst_o       (rst_o),
    .busy_o      (busy_o),
    .ready_o     (ready_o),
    .timeout_o   (timeout_o)
  );

  reset_seq #(.ACK_TIMEOUT(0)) dut_nt (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .lock_i      (lock_i),
    .soft_rst_i  (soft_rst_i),
    .stage_ack_i (ack),
    .rst_o       (rst_o_nt),
    .busy_o      (busy_nt),
    .ready_o     (ready_nt),
    .timeout_o   (timeout_nt)
  );

  function automatic logic [5:0] ex(input logic [2:0] rr, input logic b, input logic rd, input logic t);
    return {rr, b, rd, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic to_edge(input int n);
    while (edge_n < n) tick();
  endtask

  task automatic chk(input string nm, input logic [5:0] got, input logic [5:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @edge %0d: got rst/busy/ready/to=%b_%b_%b_%b want %b_%b_%b_%b",
               nm, edge_n, got[5:3], got[2], got[1], got[0], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  wire [5:0] w_o  = {rst_o, busy_o, ready_o, timeout_o};
  wire [5:0] w_nt = {rst_o_nt, busy_nt, ready_nt, timeout_nt};

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0,  3'b111, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{17, 3'b111, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{18, 3'b110, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{26, 3'b110, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{27, 3'b100, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{35, 3'b100, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{36, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{37, 3'b000, 1'b0, 1'b1, 1'b0};
    // edge 0 is the last edge sampling rst_i high
    repeat (3) tick();
    edge_n = 0;
    for (int i = 0; i < 8; i++) begin
      to_edge(tbl[i].e);
      chk($sformatf("seq_e%0d", tbl[i].e), w_o, ex(tbl[i].r, tbl[i].b, tbl[i].rd, tbl[i].t));
      if (i == 0) rst_i = 1'b0;
    end
    // one-cycle lock drop in DONE
    lock_i = 1'b0;
    tick();
    lock_i = 1'b1;
    tick();
    chk("lock_drop_e2", w_o, ex(3'b000, 1'b0, 1'b1, 1'b0));
    tick();
    chk("lock_drop_e3", w_o, ex(3'b111, 1'b1, 1'b0, 1'b0));
    ack = 3'b101;
    to_edge(55);
    chk("relock_hold", w_o, ex(3'b111, 1'b1, 1'b0, 1'b0));
    to_edge(56);
    chk("relock_rel0", w_o, ex(3'b110, 1'b1, 1'b0, 1'b0));
    to_edge(1088);
    chk("pre_timeout", w_o, ex(3'b100, 1'b1, 1'b0, 1'b0));
    to_edge(1089);
    chk("timeout", w_o, ex(3'b100, 1'b1, 1'b0, 1'b1));
    to_edge(1096);
    chk("timeout_gap", w_o, ex(3'b100, 1'b1, 1'b0, 1'b1));
    to_edge(1097);
    chk("timeout_rel2", w_o, ex(3'b000, 1'b1, 1'b0, 1'b1));
    to_edge(1098);
    chk("timeout_done", w_o, ex(3'b000, 1'b0, 1'b1, 1'b1));
    chk("no_timeout_stuck", w_nt, ex(3'b100, 1'b1, 1'b0, 1'b0));
    to_edge(1100);
    lock_i = 1'b0;
    tick();
    lock_i = 1'b1;
    tick();
    chk("to_hold", w_o, ex(3'b000, 1'b0, 1'b1, 1'b1));
    tick();
    chk("abort_clr_to", w_o, ex(3'b111, 1'b1, 1'b0, 1'b0));
    chk("abort_nt", w_nt, ex(3'b111, 1'b1, 1'b0, 1'b0));
    // lock toggling faster than the hold time never releases anything
    ack = 3'b111;
    for (int i = 0; i < 7; i++) begin
      lock_i = i[0];
      repeat (10) tick();
      chk($sformatf("toggle_%0d", i), w_o, ex(3'b111, 1'b1, 1'b0, 1'b0));
    end
    l = edge_n;
    lock_i = 1'b1;
    to_edge(l + 17);
    chk("soft_pre_hold", w_o, ex(3'b111, 1'b1, 1'b0, 1'b0));
    to_edge(l + 18);
    chk("soft_pre_rel0", w_o, ex(3'b110, 1'b1, 1'b0, 1'b0));
    soft_rst_i = 1'b1;
    tick();
    soft_rst_i = 1'b0;
    chk("soft_with_ack", w_o, ex(3'b111, 1'b1, 1'b0, 1'b0));
    to_edge(l + 35);
    chk("soft_rel0_again", w_o, ex(3'b110, 1'b1, 1'b0, 1'b0));
    to_edge(l + 37);
    soft_rst_i = 1'b1;
    tick();
    soft_rst_i = 1'b0;
    chk("soft_in_gap", w_o, ex(3'b111, 1'b1, 1'b0, 1'b0));
    // rst_i in the middle of WAIT_ACK(1)
    a = edge_n;
    ack = 3'b101;
    to_edge(a + 25);
    chk("wait1", w_o, ex(3'b100, 1'b1, 1'b0, 1'b0));
    to_edge(a + 27);
    rst_i = 1'b1;
    tick();
    chk("rst_mid_wait", w_o, ex(3'b111, 1'b1, 1'b0, 1'b0));
    rst_i = 1'b0;
    r = edge_n;
    to_edge(r + 17);
    chk("post_rst_hold", w_o, ex(3'b111, 1'b1, 1'b0, 1'b0));
    to_edge(r + 18);
    chk("post_rst_rel0", w_o, ex(3'b110, 1'b1, 1'b0, 1'b0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
